// File: rtl/volume_meter_ph.sv
// -----------------------------------------------------------------------------
// volume_meter_ph
//
// Clocked vertical level meter for the 96x64 OLED. It takes the quantised mic
// level once per frame and smooths it with a slow fall-off. It keeps a
// peak-hold marker and a clip indicator. For every pixel coordinate presented
// on X/Y, it returns the RGB565 colour of that pixel one clock later.
//
// Ports
//   clk           pixel/system clock
//   rst_n         asynchronous active-low reset
//   frame_tick    one-cycle pulse per OLED frame; all meter state moves on it
//   level         instantaneous mic level (clamped to SEGMENTS internally)
//   X, Y          pixel column 0..95 / row 0..63 being rendered
//   border_en     draw a screen border
//   border_thick  0 = 1-pixel border, 1 = 3-pixel border
//   peak_hold_en  enable the held-peak marker
//   colour        registered RGB565 colour for the previous cycle's X/Y
//   disp_level    smoothed (displayed) level
//   peak_level    held peak level
//   clip          clip indicator, stretched over CLIP_FRAMES frames
// -----------------------------------------------------------------------------
module volume_meter_ph #(
  parameter int SEGMENTS     = 15,
  parameter int LVL_W        = 4,
  parameter int GREEN_SEGS   = 5,
  parameter int YELLOW_SEGS  = 5,
  parameter int SEG_H        = 3,
  parameter int SEG_GAP      = 1,
  parameter int BASE_Y       = 60,
  parameter int BAR_X0       = 43,
  parameter int BAR_W        = 11,
  parameter int DECAY_FRAMES = 4,
  parameter int HOLD_FRAMES  = 30,
  parameter int CLIP_FRAMES  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic [LVL_W-1:0] level,
  input  logic [6:0]       X,
  input  logic [5:0]       Y,
  input  logic             border_en,
  input  logic             border_thick,
  input  logic             peak_hold_en,
  output logic [15:0]      colour,
  output logic [LVL_W-1:0] disp_level,
  output logic [LVL_W-1:0] peak_level,
  output logic             clip
);

  localparam int PITCH    = SEG_H + SEG_GAP;
  localparam int SCREEN_W = 96;
  localparam int SCREEN_H = 64;

  localparam logic [15:0] C_BLACK  = 16'h0000;
  localparam logic [15:0] C_GREEN  = 16'h07E0;
  localparam logic [15:0] C_YELLOW = 16'hFFE0;
  localparam logic [15:0] C_RED    = 16'hF800;
  localparam logic [15:0] C_WHITE  = 16'hFFFF;

  // Counter widths; a frame count of 1 still needs a 1-bit register.
  localparam int DCNT_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam int HCNT_W = (HOLD_FRAMES  > 1) ? $clog2(HOLD_FRAMES)  : 1;
  localparam int CCNT_W = (CLIP_FRAMES  > 1) ? $clog2(CLIP_FRAMES)  : 1;

  localparam logic [DCNT_W-1:0] DECAY_LAST = DCNT_W'(DECAY_FRAMES - 1);
  localparam logic [HCNT_W-1:0] HOLD_LAST  = HCNT_W'(HOLD_FRAMES - 1);
  localparam logic [CCNT_W-1:0] CLIP_LAST  = CCNT_W'(CLIP_FRAMES - 1);
  localparam logic [LVL_W-1:0]  SEG_MAX    = LVL_W'(SEGMENTS);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [LVL_W-1:0]  disp_q, disp_d;
  logic [LVL_W-1:0]  peak_q, peak_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [CCNT_W-1:0] ccnt_q, ccnt_d;
  logic              clip_q, clip_d;
  logic [15:0]       colour_q, colour_d;

  logic [LVL_W-1:0]  lvl_c;

  // The quantiser can overshoot the bar height; anything above is a full bar.
  assign lvl_c = (level > SEG_MAX) ? SEG_MAX : level;

  // ---------------------------------------------------------------------------
  // Frame-synchronous meter state: fall-off, peak hold, clip stretch
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold value first, so a path that does not
    // assign it cannot infer a latch.
    disp_d = disp_q;
    dcnt_d = dcnt_q;
    peak_d = peak_q;
    hcnt_d = hcnt_q;
    clip_d = clip_q;
    ccnt_d = ccnt_q;

    if (frame_tick) begin
      // A rise is tested first, so it overrides a decay due on the same frame.
      // lvl_c >= 0 always holds, so a zero display can never decrement.
      if (lvl_c >= disp_q) begin
        disp_d = lvl_c;
        dcnt_d = '0;
      end else if (dcnt_q == DECAY_LAST) begin
        disp_d = disp_q - 1'b1;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end

      // When the hold expires, the peak drops to this frame's new displayed level.
      if (peak_hold_en) begin
        if (lvl_c >= peak_q) begin
          peak_d = lvl_c;
          hcnt_d = '0;
        end else if (hcnt_q == HOLD_LAST) begin
          peak_d = disp_d;
          hcnt_d = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end else begin
        peak_d = disp_d;
        hcnt_d = '0;
      end

      if (lvl_c == SEG_MAX) begin
        clip_d = 1'b1;
        ccnt_d = '0;
      end else if (clip_q && (ccnt_q == CLIP_LAST)) begin
        clip_d = 1'b0;
        ccnt_d = '0;
      end else if (clip_q) begin
        ccnt_d = ccnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel renderer
  // ---------------------------------------------------------------------------
  logic             seg_hit;
  logic [LVL_W-1:0] seg_idx;
  logic             in_cols;
  logic             on_border;
  logic [15:0]      zone_colour;

  // Find the segment whose rows contain Y. The row arithmetic uses signed ints,
  // so a segment that would lie above row 0 simply never matches.
  always_comb begin
    int y_s;
    int bot;
    int top;
    y_s     = int'(Y);
    bot     = 0;
    top     = 0;
    seg_hit = 1'b0;
    seg_idx = '0;
    for (int k = 1; k <= SEGMENTS; k++) begin
      bot = BASE_Y - (k - 1) * PITCH;
      top = bot - (SEG_H - 1);
      if ((y_s >= top) && (y_s <= bot)) begin
        seg_hit = 1'b1;
        seg_idx = LVL_W'(k);
      end
    end
  end

  always_comb begin
    int x_s;
    int y_s;
    int thick;
    x_s       = int'(X);
    y_s       = int'(Y);
    thick     = border_thick ? 3 : 1;
    in_cols   = (x_s >= BAR_X0) && (x_s <= BAR_X0 + BAR_W - 1);
    on_border = border_en &&
                ((x_s < thick) || (x_s >= SCREEN_W - thick) ||
                 (y_s < thick) || (y_s >= SCREEN_H - thick));
  end

  always_comb begin
    if (int'(seg_idx) <= GREEN_SEGS) begin
      zone_colour = C_GREEN;
    end else if (int'(seg_idx) <= GREEN_SEGS + YELLOW_SEGS) begin
      zone_colour = C_YELLOW;
    end else begin
      zone_colour = C_RED;
    end
  end

  // Priority: lit segment, peak marker, border, black. Gap rows give
  // seg_hit=0, so they fall through to the border or black.
  always_comb begin
    colour_d = C_BLACK;
    if (seg_hit && in_cols && (seg_idx <= disp_q)) begin
      colour_d = zone_colour;
    end else if (seg_hit && in_cols && peak_hold_en &&
                 (seg_idx == peak_q) && (peak_q > disp_q)) begin
      colour_d = C_WHITE;
    end else if (on_border) begin
      colour_d = clip_q ? C_RED : C_WHITE;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments. All of them then
  // update together after every block has read the old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q   <= '0;
      dcnt_q   <= '0;
      peak_q   <= '0;
      hcnt_q   <= '0;
      clip_q   <= 1'b0;
      ccnt_q   <= '0;
      colour_q <= C_BLACK;
    end else begin
      disp_q   <= disp_d;
      dcnt_q   <= dcnt_d;
      peak_q   <= peak_d;
      hcnt_q   <= hcnt_d;
      clip_q   <= clip_d;
      ccnt_q   <= ccnt_d;
      colour_q <= colour_d;
    end
  end

  assign colour     = colour_q;
  assign disp_level = disp_q;
  assign peak_level = peak_q;
  assign clip       = clip_q;

endmodule

// File: tb/tb_volume_meter_ph.sv
// -----------------------------------------------------------------------------
// tb_volume_meter_ph
//
// Self-checking bench for volume_meter_ph. The level input is widened to 5 bits
// so that over-range levels can be driven. A frame-level reference model
// predicts every output, and a compare process checks the outputs on each
// falling clock edge. Directed phases pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_volume_meter_ph;

  localparam int LW           = 5;
  localparam int SEGMENTS     = 15;
  localparam int GREEN_SEGS   = 5;
  localparam int YELLOW_SEGS  = 5;
  localparam int SEG_H        = 3;
  localparam int PITCH        = 4;
  localparam int BASE_Y       = 60;
  localparam int BAR_X0       = 43;
  localparam int BAR_W        = 11;
  localparam int DECAY_FRAMES = 4;
  localparam int HOLD_FRAMES  = 30;
  localparam int CLIP_FRAMES  = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic [LW-1:0] level = '0;
  logic [6:0]    X = '0;
  logic [5:0]    Y = '0;
  logic          border_en = 1'b0;
  logic          border_thick = 1'b0;
  logic          peak_hold_en = 1'b0;
  logic [15:0]   colour;
  logic [LW-1:0] disp_level;
  logic [LW-1:0] peak_level;
  logic          clip;

  volume_meter_ph #(.LVL_W(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .level        (level),
    .X            (X),
    .Y            (Y),
    .border_en    (border_en),
    .border_thick (border_thick),
    .peak_hold_en (peak_hold_en),
    .colour       (colour),
    .disp_level   (disp_level),
    .peak_level   (peak_level),
    .clip         (clip)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: meter state in frames, pixel colour from screen geometry
  // ---------------------------------------------------------------------------
  int          m_disp, m_dcnt, m_peak, m_hcnt, m_clip, m_ccnt;
  logic [15:0] exp_colour = '0;

  function automatic logic [15:0] model_pixel(int x, int y, int disp, int peak, int clp,
                                               bit pen, bit ben, bit bth);
    int d, k, t;
    k = 0;
    d = BASE_Y - y;
    if (d >= 0 && (d % PITCH) < SEG_H && (d / PITCH) < SEGMENTS) k = d / PITCH + 1;
    if (k != 0 && x >= BAR_X0 && x < BAR_X0 + BAR_W) begin
      if (k <= disp) begin
        if (k <= GREEN_SEGS) return 16'h07E0;
        if (k <= GREEN_SEGS + YELLOW_SEGS) return 16'hFFE0;
        return 16'hF800;
      end
      if (pen && k == peak && peak > disp) return 16'hFFFF;
    end
    t = bth ? 3 : 1;
    if (ben && (x < t || x >= 96 - t || y < t || y >= 64 - t))
      return (clp != 0) ? 16'hF800 : 16'hFFFF;
    return 16'h0000;
  endfunction

  initial begin
    m_disp = 0; m_dcnt = 0; m_peak = 0; m_hcnt = 0; m_clip = 0; m_ccnt = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_disp = 0; m_dcnt = 0; m_peak = 0; m_hcnt = 0; m_clip = 0; m_ccnt = 0;
        exp_colour = 16'h0000;
      end else begin
        int lc;
        exp_colour = model_pixel(int'(X), int'(Y), m_disp, m_peak, m_clip,
                                 peak_hold_en, border_en, border_thick);
        if (frame_tick) begin
          lc = (int'(level) > SEGMENTS) ? SEGMENTS : int'(level);
          if (lc >= m_disp) begin m_disp = lc; m_dcnt = 0; end
          else if (m_dcnt == DECAY_FRAMES - 1) begin m_disp--; m_dcnt = 0; end
          else m_dcnt++;
          if (!peak_hold_en) begin m_peak = m_disp; m_hcnt = 0; end
          else if (lc >= m_peak) begin m_peak = lc; m_hcnt = 0; end
          else if (m_hcnt == HOLD_FRAMES - 1) begin m_peak = m_disp; m_hcnt = 0; end
          else m_hcnt++;
          if (lc == SEGMENTS) begin m_clip = 1; m_ccnt = 0; end
          else if (m_clip != 0 && m_ccnt == CLIP_FRAMES - 1) begin m_clip = 0; m_ccnt = 0; end
          else if (m_clip != 0) m_ccnt++;
        end
      end
    end
  end

  // Compare process: outputs are stable at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("colour",     colour,     exp_colour);
        check("disp_level", disp_level, m_disp);
        check("peak_level", peak_level, m_peak);
        check("clip",       clip,       m_clip);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int lv);
    level      = LW'(lv);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic pixel(input string name, input int x, input int y, input logic [15:0] exp);
    X = 7'(x);
    Y = 6'(y);
    cyc(1);
    check(name, colour, exp);
  endtask

  initial begin
    // Reset state
    cyc(3);
    check("rst_colour", colour, 16'h0000);
    check("rst_disp",   disp_level, 0);
    check("rst_peak",   peak_level, 0);
    check("rst_clip",   clip, 0);
    cmp_en = 1'b1;
    rst_n  = 1'b1;
    peak_hold_en = 1'b1;
    cyc(2);

    // Rise, then fall by one segment every four frames
    tick(10);
    check("rise_10", disp_level, 10);
    for (int i = 1; i <= 40; i++) begin
      tick(0);
      if (i == 3)  check("decay_hold3", disp_level, 10);
      if (i == 4)  check("decay_9",  disp_level, 9);
      if (i == 39) check("decay_1",  disp_level, 1);
      if (i == 40) check("decay_0",  disp_level, 0);
    end

    // Rendering with disp=6
    tick(6);
    pixel("px_green",  48, 58, 16'h07E0);
    pixel("px_yellow", 48, 38, 16'hFFE0);
    pixel("px_unlit",  48, 34, 16'h0000);
    pixel("px_gap",    48, 57, 16'h0000);
    pixel("px_leftof", 42, 58, 16'h0000);

    // Peak hold: marker on segment 12 while the bar falls
    X = 7'd48;
    Y = 6'd14;
    tick(12);
    for (int i = 1; i <= 30; i++) begin
      tick(3);
      if (i == 10) check("peak_marker", colour, 16'hFFFF);
      if (i == 29) check("peak_held",   peak_level, 12);
      if (i == 30) check("peak_drop",   peak_level, 5);
    end
    cyc(1);
    check("peak_marker_gone", colour, 16'h0000);

    // Peak follows the displayed level when the hold is disabled
    peak_hold_en = 1'b0;
    tick(7);
    check("nohold_peak_a", peak_level, 7);
    tick(2);
    check("nohold_peak_b", peak_level, 7);
    peak_hold_en = 1'b1;

    // Clip stretching and border colour
    border_en    = 1'b1;
    border_thick = 1'b1;
    X = 7'd1;
    Y = 6'd30;
    tick(15);
    check("clip_set", clip, 1);
    for (int i = 1; i <= 15; i++) begin
      tick(0);
      if (i == 14) begin
        cyc(1);
        check("border_red", colour, 16'hF800);
      end
      if (i == 15) begin
        check("clip_clear", clip, 0);
        cyc(1);
        check("border_white", colour, 16'hFFFF);
      end
    end
    border_thick = 1'b0;
    cyc(1);
    check("thin_border_off", colour, 16'h0000);
    tick(20);
    check("clamp_disp", disp_level, 15);
    check("clamp_clip", clip, 1);

    // A rise on the frame a decay is due resets the decay count
    for (int i = 0; i < 3; i++) tick(0);
    tick(15);
    for (int i = 0; i < 3; i++) tick(0);
    check("rise_wins", disp_level, 15);

    // No frame_tick: state is frozen regardless of inputs
    for (int i = 0; i < 100; i++) begin
      level = LW'($urandom_range(0, 31));
      X     = 7'($urandom_range(0, 95));
      Y     = 6'($urandom_range(0, 63));
      cyc(1);
    end
    check("frozen_disp", disp_level, 15);
    check("frozen_clip", clip, 1);

    // Asynchronous reset mid-cycle
    level = LW'(9);
    border_en = 1'b1;
    X = 7'd0;
    Y = 6'd0;
    cyc(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_colour", colour, 16'h0000);
    check("arst_disp",   disp_level, 0);
    check("arst_peak",   peak_level, 0);
    check("arst_clip",   clip, 0);
    cyc(2);
    rst_n = 1'b1;
    border_en = 1'b0;
    cyc(3);
    check("post_rst_disp", disp_level, 0);
    check("post_rst_clip", clip, 0);
    tick(9);
    check("post_rst_tick", disp_level, 9);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      frame_tick = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      if (r < 5)      level = LW'($urandom_range(0, 8));
      else if (r < 9) level = LW'($urandom_range(0, 15));
      else            level = LW'($urandom_range(16, 31));
      if ($urandom_range(0, 1) == 0) X = 7'($urandom_range(40, 56));
      else                           X = 7'($urandom_range(0, 95));
      Y = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 63) == 0) border_en    = ~border_en;
      if ($urandom_range(0, 63) == 0) border_thick = ~border_thick;
      if ($urandom_range(0, 127) == 0) peak_hold_en = ~peak_hold_en;
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
      end
      cyc(1);
    end

    frame_tick = 1'b0;
    cyc(2);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
